// File: rtl/motor_arbiter.sv
// Purpose : arbitrates estop / manual / autonomous motor commands, inserts dead-time
//           between opposing commands and ramps wheel PWM duty on a 1 ms tick.
// Latency : 1 cycle from selected command to registered outputs; no backpressure (level inputs).
// Ports   : clk, reset (async active-low); auto_cmd/man_cmd one-hot commands, man_req, estop in;
//           applied_cmd, grant, l_pwm/r_pwm, l_dir/r_dir, busy out (all registered).
module motor_arbiter #(
  parameter int CLKS_PER_MS = 50000,
  parameter int DEADTIME_MS = 20,
  parameter int RAMP_STEP   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] auto_cmd,
  input  logic       man_req,
  input  logic [4:0] man_cmd,
  input  logic       estop,
  output logic [4:0] applied_cmd,
  output logic [1:0] grant,
  output logic       l_pwm,
  output logic       r_pwm,
  output logic       l_dir,
  output logic       r_dir,
  output logic       busy
);

  localparam int TW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int DW = (DEADTIME_MS > 1) ? $clog2(DEADTIME_MS + 1) : 1;
  localparam logic [8:0] RAMP9 = 9'(RAMP_STEP);

  localparam logic [4:0] CMD_STOP  = 5'b00001;
  localparam logic [4:0] CMD_FWD   = 5'b00010;
  localparam logic [4:0] CMD_RIGHT = 5'b00100;
  localparam logic [4:0] CMD_LEFT  = 5'b01000;
  localparam logic [4:0] CMD_SPIN  = 5'b10000;

  typedef enum logic [1:0] {S_HALT, S_DRIVE, S_DEAD, S_ESTOP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  applied_cmd_q, applied_cmd_d;
  logic [1:0]  grant_q, grant_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] dt_cnt_q, dt_cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic        l_pwm_q, l_pwm_d, r_pwm_q, r_pwm_d;
  logic        l_dir_q, l_dir_d, r_dir_q, r_dir_d;
  logic        busy_q, busy_d;

  logic        tick;
  logic [4:0]  sel_cmd;
  logic [8:0]  duty_sum;
  logic        l_en, r_en;

  function automatic logic is_onehot(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  // Fixed-priority selection; a malformed command from the winner degrades to STOP.
  // Auto only reports ownership when it actually asks for motion.
  always_comb begin
    sel_cmd = CMD_STOP;
    grant_d = 2'b00;
    if (estop) begin
      grant_d = 2'b11;
    end else if (man_req) begin
      grant_d = 2'b10;
      if (is_onehot(man_cmd)) sel_cmd = man_cmd;
    end else if (is_onehot(auto_cmd) && auto_cmd != CMD_STOP) begin
      sel_cmd = auto_cmd;
      grant_d = 2'b01;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TW'(CLKS_PER_MS - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_comb begin
    state_d       = state_q;
    applied_cmd_d = applied_cmd_q;
    dt_cnt_d      = dt_cnt_q;
    if (estop) begin
      state_d       = S_ESTOP;
      applied_cmd_d = CMD_STOP;
    end else begin
      case (state_q)
        S_HALT: begin
          applied_cmd_d = CMD_STOP;
          if (sel_cmd != CMD_STOP) begin
            state_d       = S_DRIVE;
            applied_cmd_d = sel_cmd;
          end
        end
        S_DRIVE: begin
          if (sel_cmd == CMD_STOP) begin
            state_d       = S_HALT;
            applied_cmd_d = CMD_STOP;
          end else if (sel_cmd != applied_cmd_q) begin
            state_d       = S_DEAD;
            applied_cmd_d = CMD_STOP;
            dt_cnt_d      = '0;
          end
        end
        S_DEAD: begin
          // Only ticks seen while already in dead-time count; the command is
          // sampled at expiry so the latest request wins.
          if (tick) begin
            if (dt_cnt_q == DW'(DEADTIME_MS - 1)) begin
              state_d       = (sel_cmd == CMD_STOP) ? S_HALT : S_DRIVE;
              applied_cmd_d = sel_cmd;
            end else begin
              dt_cnt_d = dt_cnt_q + DW'(1);
            end
          end
        end
        default: begin
          state_d       = S_DEAD;
          applied_cmd_d = CMD_STOP;
          dt_cnt_d      = '0;
        end
      endcase
    end
  end

  // Duty restarts from zero whenever the driven command changes.
  always_comb begin
    duty_sum = {1'b0, duty_q} + RAMP9;
    duty_d   = duty_q;
    if (state_d != S_DRIVE || applied_cmd_d != applied_cmd_q) begin
      duty_d = 8'd0;
    end else if (tick) begin
      duty_d = duty_sum[8] ? 8'hff : duty_sum[7:0];
    end
  end

  // Outputs are computed from next-state values so the registered wheel
  // signals line up with the registered applied_cmd.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    l_en      = (applied_cmd_d == CMD_FWD) || (applied_cmd_d == CMD_RIGHT) || (applied_cmd_d == CMD_SPIN);
    r_en      = (applied_cmd_d == CMD_FWD) || (applied_cmd_d == CMD_LEFT)  || (applied_cmd_d == CMD_SPIN);
    l_pwm_d   = l_en && (pwm_cnt_d < duty_d);
    r_pwm_d   = r_en && (pwm_cnt_d < duty_d);
    l_dir_d   = 1'b1;
    r_dir_d   = (applied_cmd_d != CMD_SPIN);
    busy_d    = (state_d == S_DEAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_HALT;
      applied_cmd_q <= CMD_STOP;
      grant_q       <= 2'b00;
      tick_cnt_q    <= '0;
      dt_cnt_q      <= '0;
      duty_q        <= 8'd0;
      pwm_cnt_q     <= 8'd0;
      l_pwm_q       <= 1'b0;
      r_pwm_q       <= 1'b0;
      l_dir_q       <= 1'b1;
      r_dir_q       <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      applied_cmd_q <= applied_cmd_d;
      grant_q       <= grant_d;
      tick_cnt_q    <= tick_cnt_d;
      dt_cnt_q      <= dt_cnt_d;
      duty_q        <= duty_d;
      pwm_cnt_q     <= pwm_cnt_d;
      l_pwm_q       <= l_pwm_d;
      r_pwm_q       <= r_pwm_d;
      l_dir_q       <= l_dir_d;
      r_dir_q       <= r_dir_d;
      busy_q        <= busy_d;
    end
  end

  assign applied_cmd = applied_cmd_q;
  assign grant       = grant_q;
  assign l_pwm       = l_pwm_q;
  assign r_pwm       = r_pwm_q;
  assign l_dir       = l_dir_q;
  assign r_dir       = r_dir_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_motor_arbiter.sv
// Purpose : self-checking bench for motor_arbiter (directed table, corner sequences, random vs model).
// Latency : n/a.
// Ports   : none; drives inputs on the falling edge, samples outputs on the falling edge.
module tb_motor_arbiter;

  localparam int CPM  = 4;
  localparam int DT   = 2;
  localparam int RAMP = 64;

  localparam logic [4:0] STOP  = 5'b00001;
  localparam logic [4:0] FWD   = 5'b00010;
  localparam logic [4:0] RIGHT = 5'b00100;
  localparam logic [4:0] LEFT  = 5'b01000;
  localparam logic [4:0] SPIN  = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] auto_cmd = STOP;
  logic       man_req = 1'b0;
  logic [4:0] man_cmd = STOP;
  logic       estop = 1'b0;
  logic [4:0] applied_cmd;
  logic [1:0] grant;
  logic       l_pwm, r_pwm, l_dir, r_dir, busy;

  int n_checks = 0;
  int n_pass   = 0;

  motor_arbiter #(.CLKS_PER_MS(CPM), .DEADTIME_MS(DT), .RAMP_STEP(RAMP)) dut (
    .clk(clk), .reset(reset), .auto_cmd(auto_cmd), .man_req(man_req), .man_cmd(man_cmd),
    .estop(estop), .applied_cmd(applied_cmd), .grant(grant), .l_pwm(l_pwm), .r_pwm(r_pwm),
    .l_dir(l_dir), .r_dir(r_dir), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_HALT = 0, M_DRIVE = 1, M_DEAD = 2, M_ESTOP = 3;
  int         m_mode, m_ticks_seen, m_clk_in_ms, m_duty, m_pwm;
  logic [4:0] m_cmd;
  logic [1:0] m_grant;

  task automatic model_reset();
    m_mode = M_HALT; m_ticks_seen = 0; m_clk_in_ms = 0; m_duty = 0; m_pwm = 0;
    m_cmd = STOP; m_grant = 2'b00;
  endtask

  function automatic bit valid_cmd(input logic [4:0] c);
    return $countones(c) == 1;
  endfunction

  task automatic model_step(input logic [4:0] a, input logic mr, input logic [4:0] mc, input logic e);
    bit         tick;
    logic [4:0] sel;
    logic [4:0] old_cmd;
    tick = (m_clk_in_ms == CPM - 1);
    m_clk_in_ms = (m_clk_in_ms + 1) % CPM;
    if (e) begin sel = STOP; m_grant = 2'b11; end
    else if (mr) begin sel = valid_cmd(mc) ? mc : STOP; m_grant = 2'b10; end
    else begin sel = valid_cmd(a) ? a : STOP; m_grant = (sel == STOP) ? 2'b00 : 2'b01; end
    old_cmd = m_cmd;
    if (e) begin
      m_mode = M_ESTOP; m_cmd = STOP;
    end else if (m_mode == M_HALT) begin
      if (sel != STOP) begin m_mode = M_DRIVE; m_cmd = sel; end
    end else if (m_mode == M_DRIVE) begin
      if (sel == STOP) begin m_mode = M_HALT; m_cmd = STOP; end
      else if (sel != m_cmd) begin m_mode = M_DEAD; m_cmd = STOP; m_ticks_seen = 0; end
    end else if (m_mode == M_DEAD) begin
      if (tick) m_ticks_seen++;
      if (m_ticks_seen == DT) begin
        m_mode = (sel == STOP) ? M_HALT : M_DRIVE;
        m_cmd  = sel;
      end
    end else begin
      m_mode = M_DEAD; m_cmd = STOP; m_ticks_seen = 0;
    end
    if (m_mode != M_DRIVE || m_cmd != old_cmd) m_duty = 0;
    else if (tick) m_duty = (m_duty + RAMP > 255) ? 255 : m_duty + RAMP;
    m_pwm = (m_pwm + 1) % 256;
  endtask

  function automatic logic [12:0] model_vec();
    bit len, ren;
    len = (m_cmd == FWD) || (m_cmd == RIGHT) || (m_cmd == SPIN);
    ren = (m_cmd == FWD) || (m_cmd == LEFT)  || (m_cmd == SPIN);
    return {m_cmd, m_grant, len && (m_pwm < m_duty), ren && (m_pwm < m_duty),
            1'b1, (m_cmd != SPIN), (m_mode == M_DEAD)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {applied_cmd, grant, l_pwm, r_pwm, l_dir, r_dir, busy};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cmd/grant/lp/rp/ld/rd/busy packed)", name, act, exp);
  endtask

  task automatic cycle(input logic [4:0] a, input logic mr, input logic [4:0] mc, input logic e,
                       input string name);
    auto_cmd = a; man_req = mr; man_cmd = mc; estop = e;
    @(posedge clk);
    model_step(a, mr, mc, e);
    @(negedge clk);
    check(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Reset is asserted away from the clock edge; outputs must drop at once.
  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check(name, 32'(dut_vec()), 32'({STOP, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [4:0] a;
    logic       mr;
    logic [4:0] mc;
    logic       e;
    logic [4:0] x_cmd;
    logic [1:0] x_grant;
    logic       x_busy;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic [4:0] a, input logic mr, input logic [4:0] mc, input logic e,
                              input logic [4:0] xc, input logic [1:0] xg, input logic xb);
    vec_t v;
    v.a = a; v.mr = mr; v.mc = mc; v.e = e; v.x_cmd = xc; v.x_grant = xg; v.x_busy = xb;
    return v;
  endfunction

  initial begin
    int cnt_l, cnt_r;
    logic [4:0] ra, rmc;
    logic rmr, re;

    // Directed sequence from reset; ticks land on edges 4, 8, 12, 16.
    tbl[0]  = mk(FWD,       0, STOP, 0, FWD,   2'b01, 0);
    tbl[1]  = mk(FWD,       0, STOP, 0, FWD,   2'b01, 0);
    tbl[2]  = mk(RIGHT,     0, STOP, 0, STOP,  2'b01, 1);
    tbl[3]  = mk(RIGHT,     0, STOP, 0, STOP,  2'b01, 1);
    tbl[4]  = mk(RIGHT,     0, STOP, 0, STOP,  2'b01, 1);
    tbl[5]  = mk(LEFT,      0, STOP, 0, STOP,  2'b01, 1);
    tbl[6]  = mk(RIGHT,     0, STOP, 0, STOP,  2'b01, 1);
    tbl[7]  = mk(RIGHT,     0, STOP, 0, RIGHT, 2'b01, 0);
    tbl[8]  = mk(RIGHT,     1, SPIN, 0, STOP,  2'b10, 1);
    tbl[9]  = mk(RIGHT,     1, SPIN, 1, STOP,  2'b11, 0);
    tbl[10] = mk(STOP,      0, STOP, 0, STOP,  2'b00, 1);
    tbl[11] = mk(STOP,      0, STOP, 0, STOP,  2'b00, 1);
    tbl[12] = mk(FWD,       0, STOP, 0, STOP,  2'b01, 1);
    tbl[13] = mk(STOP,      0, STOP, 0, STOP,  2'b00, 1);
    tbl[14] = mk(STOP,      0, STOP, 0, STOP,  2'b00, 1);
    tbl[15] = mk(STOP,      0, STOP, 0, STOP,  2'b00, 0);
    tbl[16] = mk(5'b00110,  0, STOP, 0, STOP,  2'b00, 0);
    tbl[17] = mk(LEFT,      0, STOP, 0, LEFT,  2'b01, 0);
    tbl[18] = mk(STOP,      0, STOP, 0, STOP,  2'b00, 0);

    model_reset();
    do_reset("reset_state");

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].a, tbl[i].mr, tbl[i].mc, tbl[i].e, $sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d_cmd_grant_busy", i),
            32'({applied_cmd, grant, busy}),
            32'({tbl[i].x_cmd, tbl[i].x_grant, tbl[i].x_busy}));
    end

    // Ramp to saturation, then a full PWM period must show 255 high cycles per wheel.
    for (int i = 0; i < 24; i++) cycle(FWD, 0, STOP, 0, "ramp");
    cnt_l = 0; cnt_r = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(FWD, 0, STOP, 0, "pwm_window");
      cnt_l += int'(l_pwm);
      cnt_r += int'(r_pwm);
    end
    check("l_pwm_full_duty", 32'(cnt_l), 32'd255);
    check("r_pwm_full_duty", 32'(cnt_r), 32'd255);

    // Reset in the middle of dead-time, then LEFT must apply with no dead-time.
    cycle(SPIN, 0, STOP, 0, "to_deadtime");
    check("in_deadtime", 32'(busy), 32'd1);
    do_reset("reset_mid_deadtime");
    cycle(LEFT, 0, STOP, 0, "left_after_reset");
    check("left_direct", 32'({applied_cmd, busy}), 32'({LEFT, 1'b0}));

    // Randomized inputs held for random stretches, compared against the model.
    ra = FWD; rmr = 0; rmc = STOP; re = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ra  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
        rmc = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
        rmr = ($urandom_range(0, 3) == 0);
        re  = ($urandom_range(0, 11) == 0);
      end
      if (i % 900 == 899) do_reset("random_reset");
      cycle(ra, rmr, rmc, re, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
